// File: rtl/result_drain.sv
// result_drain: serialises a captured result store into a checksummed byte frame
module result_drain #(
    parameter int NUMPOSITIONS = 5,
    parameter int VALUEBITS    = 9,
    parameter int NUMRESULTS   = 5
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic                                                 done_in,
    input  logic [5:0]                                           num_results_in,
    input  logic [(NUMPOSITIONS+1)*VALUEBITS*NUMRESULTS-1:0]     results_in,
    output logic [7:0]                                           tx_data,
    output logic                                                 tx_valid,
    input  logic                                                 tx_ready,
    output logic                                                 busy,
    output logic [7:0]                                           frames_sent
);
    localparam int W     = (NUMPOSITIONS + 1) * VALUEBITS * NUMRESULTS;
    localparam int MARKS = (NUMPOSITIONS + 1) * NUMRESULTS;
    localparam int RW    = $clog2(MARKS + 1);
    localparam logic [6:0] NRC = (NUMRESULTS > 63) ? 7'd63 : 7'(NUMRESULTS);

    typedef enum logic [2:0] {IDLE, HEADER, COUNT, HI, LO, CHK} state_t;

    state_t          state;
    logic            done_q;
    logic [W-1:0]    cap;
    logic [W-1:0]    cap_sh;
    logic [5:0]      cnt;
    logic [5:0]      cnt_in;
    logic [RW-1:0]   rem;
    logic [7:0]      chk;
    logic [15:0]     mark;
    logic [15:0]     mark_next;
    logic            xfer;
    logic            trigger;

    // Current mark is always the top field of the capture register; it shifts up one mark per LO byte
    always_comb begin
        cnt_in    = ({1'b0, num_results_in} > NRC) ? NRC[5:0] : num_results_in;
        xfer      = tx_valid & tx_ready;
        trigger   = (state == IDLE) & done_in & ~done_q;
        cap_sh    = cap << VALUEBITS;
        mark      = 16'(cap[W-1 -: VALUEBITS]);
        mark_next = 16'(cap_sh[W-1 -: VALUEBITS]);
    end

    // Frame sequencer with registered byte, valid and busy outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            cap         <= '0;
            cnt         <= '0;
            rem         <= '0;
            chk         <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
        end else begin
            done_q <= done_in;
            case (state)
                IDLE: if (trigger) begin
                    state    <= HEADER;
                    cap      <= results_in;
                    cnt      <= cnt_in;
                    rem      <= RW'(32'(cnt_in) * (NUMPOSITIONS + 1));
                    chk      <= '0;
                    tx_data  <= 8'hA5;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                end
                HEADER: if (xfer) begin
                    state   <= COUNT;
                    tx_data <= {2'b00, cnt};
                end
                COUNT: if (xfer) begin
                    chk     <= chk ^ tx_data;
                    state   <= (cnt != 6'd0) ? HI : CHK;
                    tx_data <= (cnt != 6'd0) ? mark[15:8] : chk ^ tx_data;
                end
                HI: if (xfer) begin
                    chk     <= chk ^ tx_data;
                    state   <= LO;
                    tx_data <= mark[7:0];
                end
                LO: if (xfer) begin
                    chk     <= chk ^ tx_data;
                    cap     <= cap_sh;
                    rem     <= rem - RW'(1);
                    state   <= (rem == RW'(1)) ? CHK : HI;
                    tx_data <= (rem == RW'(1)) ? chk ^ tx_data : mark_next[15:8];
                end
                CHK: if (xfer) begin
                    state       <= IDLE;
                    tx_valid    <= 1'b0;
                    busy        <= 1'b0;
                    frames_sent <= frames_sent + 8'd1;
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter NUMPOSITIONS, default 5: index of the last mark; each ruler has NUMPOSITIONS+1 marks, m[0]..m[NUMPOSITIONS].
REQ-002 Parameter VALUEBITS, default 9: bits per mark value; legal range 1..16.
REQ-003 Parameter NUMRESULTS, default 5: number of result slots in results_in.
REQ-004 Port clock, input, 1: the single clock; all logic samples on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port done_in, input, 1: search-complete flag from the search controller.
REQ-007 Port num_results_in, input, 6: count of results the controller has observed.
REQ-008 Port results_in, input, (NUMPOSITIONS+1)*VALUEBITS*NUMRESULTS: packed result store. Slot 1 occupies the most-significant bits. Within each slot, m[0] occupies the most-significant VALUEBITS.
REQ-009 Port tx_data, output, 8: byte to the host link.
REQ-010 Port tx_valid, output, 1: tx_data holds a valid byte.
REQ-011 Port tx_ready, input, 1: the host accepts the byte; a transfer occurs in a cycle where tx_valid and tx_ready are both 1.
REQ-012 Port busy, output, 1: high from the trigger until the frame's last byte is transferred.
REQ-013 Port frames_sent, output, 8: count of completed frames.

Function
REQ-014 Trigger: done_in is registered each cycle. A trigger is done_in=1 in a cycle whose registered previous value is 0, while in IDLE.
REQ-015 On trigger, capture results_in in full and capture cnt = min(num_results_in, NUMRESULTS). Later changes to either input do not affect the frame in progress.
REQ-016 States: IDLE, HEADER, COUNT, HI, LO, CHK.
- IDLE -> HEADER on trigger.
- HEADER -> COUNT on transfer.
- COUNT -> HI on transfer if cnt>0; COUNT -> CHK on transfer if cnt=0.
- HI -> LO on transfer.
- LO -> HI on transfer if marks remain; LO -> CHK after the last mark of slot cnt.
- CHK -> IDLE on transfer.
REQ-017 Bytes sent in each state:
- HEADER: 0xA5.
- COUNT: cnt.
- HI/LO: the current mark value, zero-extended to 16 bits; HI sends the high byte, LO the low byte.
- CHK: XOR of the COUNT byte and all HI/LO bytes; the header byte is excluded.
REQ-018 Mark order: slot 1..cnt; within each slot, m[0]..m[NUMPOSITIONS]. Frame length = 3 + 2*cnt*(NUMPOSITIONS+1) bytes.
REQ-019 tx_valid rises in the cycle after the trigger.
REQ-020 tx_valid stays 1 in every non-IDLE state and is 0 in IDLE.
REQ-021 tx_data holds its value while tx_valid=1 and tx_ready=0.
REQ-022 At most one byte is transferred per cycle. Back-to-back transfers are sustained with no idle cycle between bytes of a frame.
REQ-023 tx_ready is ignored while tx_valid=0.
REQ-024 busy = (state != IDLE).
REQ-025 frames_sent increments by 1 on the CHK transfer and wraps from 255 to 0.
REQ-026 done_in falling mid-frame: the frame completes unchanged.
REQ-027 done_in held high after a frame: no new frame is sent. A new frame requires done_in to go 0 and then 1 again.
REQ-028 done_in rising while the block is not in IDLE: ignored. The edge is consumed and not queued.
REQ-029 num_results_in greater than NUMRESULTS: clamped to NUMRESULTS. A value of 0 produces the 3-byte frame A5 00 00.

Reset
REQ-030 Reset values:
- state = IDLE
- tx_valid = 0
- tx_data = 0x00
- busy = 0
- frames_sent = 0
- registered done_in = 0
- captured data and cnt = 0
REQ-031 Reset asserted mid-frame aborts the frame with no checksum sent. tx_valid = 0 in the cycle after reset is sampled. frames_sent = 0.
REQ-032 If done_in is already 1 when reset is released, the first cycle after reset counts as a trigger (registered previous value is 0).

Verification
REQ-033 Defaults, cnt=1, slot 1 = 0-1-4-10-12-17, tx_ready held 1 -> 15 consecutive bytes: A5 01 00 00 00 01 00 04 00 0A 00 0C 00 11 13; frames_sent becomes 1.
REQ-034 Same stimulus, tx_ready toggling 1/0 pseudo-randomly -> identical byte sequence; tx_data stable during every stall; busy falls on the final transfer.
REQ-035 num_results_in = 0x3F (above NUMRESULTS, clamped to 5), five distinct rulers loaded -> COUNT byte 05; 63 bytes total; correct checksum.
REQ-036 num_results_in = 0 -> A5 00 00; frames_sent increments by 1.
REQ-037 Reset pulsed after byte 6 -> tx_valid = 0 the next cycle; frames_sent = 0. done_in then dropped and re-raised -> a full frame starting with A5.
REQ-038 done_in held high across two frame durations -> exactly one frame sent. A second rising edge raised mid-frame -> ignored; exactly one frame sent.
